// File: rtl/rv32_pkg.sv
// Shared RV32 store definitions: store funct3 encodings and the buffered-entry layout.
package rv32_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int SB_ADDR_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:2] addr;
        logic [31:0]          wdata;
        logic [3:0]           be;
    } sb_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store formatter: maps a store onto 32-bit byte lanes and flags illegal requests.
module store_lane_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);

    // Lane select and replication; unknown funct3 is treated as an illegal store.
    always_comb begin
        be       = 4'b0000;
        wdata    = 32'h0000_0000;
        misalign = 1'b0;
        case (funct3)
            F3_SB: begin
                be    = 4'b0001 << offset;
                wdata = {4{data[7:0]}};
            end
            F3_SH: begin
                be       = 4'b0011 << {offset[1], 1'b0};
                wdata    = {2{data[15:0]}};
                misalign = offset[0];
            end
            F3_SW: begin
                be       = 4'b1111;
                wdata    = data;
                misalign = |offset;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO of lane-aligned stores drained over req/ack,
// with misalignment pulse and load-after-store word hazard detection.
module store_buffer
    import rv32_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [2:0]                 st_funct3,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [31:0]                st_data,
    output logic                       st_ready,
    output logic                       st_misalign,
    input  logic                       ld_check,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hazard,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic                       mem_ack,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH):0]     sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_W-3:0] addr_q  [DEPTH];
    logic [ADDR_W-3:0] addr_d  [DEPTH];
    logic [31:0]       wdata_q [DEPTH];
    logic [31:0]       wdata_d [DEPTH];
    logic [3:0]        be_q    [DEPTH];
    logic [3:0]        be_d    [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              misalign_q, misalign_d;

    logic [3:0]        al_be_s;
    logic [31:0]       al_wdata_s;
    logic              al_misalign_s;
    logic              push_s, pop_s, hit_s;

    store_lane_align u_align (
        .funct3   (st_funct3),
        .offset   (st_addr[1:0]),
        .data     (st_data),
        .be       (al_be_s),
        .wdata    (al_wdata_s),
        .misalign (al_misalign_s)
    );

    assign st_ready    = (count_q != FULL_CNT);
    assign mem_req     = (count_q != {CW{1'b0}});
    assign sb_empty    = ~mem_req;
    assign sb_count    = count_q;
    assign st_misalign = misalign_q;
    assign mem_addr    = {addr_q[head_q], 2'b00};
    assign mem_wdata   = wdata_q[head_q];
    assign mem_be      = mem_req ? be_q[head_q] : 4'b0000;

    // Full blocks pushes even when the head retires this cycle; there is no bypass path.
    assign push_s = st_valid & st_ready & ~al_misalign_s;
    assign pop_s  = mem_req & mem_ack;

    // Word-granular match against entries already stored; the entry being pushed is not visible yet.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s | (valid_q[i] & (addr_q[i] == ld_addr[ADDR_W-1:2]));
        end
    end

    assign ld_hazard = ld_check & hit_s;

    // Next-state for storage, pointers, occupancy and the rejection pulse.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        misalign_d = st_valid & st_ready & al_misalign_s;
        if (push_s) begin
            addr_d[tail_q]  = st_addr[ADDR_W-1:2];
            wdata_d[tail_q] = al_wdata_s;
            be_d[tail_q]    = al_be_s;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every pending store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= 32'h0000_0000;
                be_q[i]    <= 4'b0000;
            end
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic vs a queue model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_misalign;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    logic exp_mis = 1'b0;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .st_misalign(st_misalign),
        .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    function automatic bit m_legal(input logic [2:0] f, input logic [31:0] a);
        return (f == 3'd0) || (f == 3'd1 && a[0] == 1'b0) || (f == 3'd2 && a[1:0] == 2'd0);
    endfunction

    function automatic ent_t m_entry(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        int   o;
        o       = int'(a[1:0]);
        e.addr  = a & 32'hFFFF_FFFC;
        if (f == 3'd0) begin
            e.be    = 4'(1 << o);
            e.wdata = (d & 32'hFF) * 32'h0101_0101;
        end else if (f == 3'd1) begin
            e.be    = 4'(3 << (o & 2));
            e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.be    = 4'hF;
            e.wdata = d;
        end
        return e;
    endfunction

    function automatic logic m_hazard();
        logic h = 1'b0;
        foreach (q[i]) if (q[i].addr == (ld_addr & 32'hFFFF_FFFC)) h = 1'b1;
        return ld_check & h;
    endfunction

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic ack);
        st_valid = v; st_funct3 = f; st_addr = a; st_data = d; mem_ack = ack;
    endtask

    // One clock: model decides from pre-edge inputs, DUT is sampled 1 time unit after the edge.
    task automatic tick();
        bit   accept, do_push, do_pop, nxt_mis;
        ent_t e;
        accept  = st_valid && (q.size() < DEPTH);
        do_push = accept && m_legal(st_funct3, st_addr);
        nxt_mis = accept && !m_legal(st_funct3, st_addr);
        do_pop  = (q.size() > 0) && mem_ack;
        e       = m_entry(st_funct3, st_addr, st_data);
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        exp_mis = nxt_mis;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        ld_check = 1'b0; ld_addr = 32'h0;
        q.delete(); exp_mis = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain_check(input string tag);
        for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== q[0].addr || mem_wdata !== q[0].wdata || mem_be !== q[0].be) begin
                errors++;
                $display("FAIL %s_order: got req=%b addr=%h wdata=%h be=%b exp addr=%h wdata=%h be=%b",
                         tag, mem_req, mem_addr, mem_wdata, mem_be, q[0].addr, q[0].wdata, q[0].be);
            end
            drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (sb_empty !== 1'b1 || sb_count !== 3'd0) begin
            errors++;
            $display("FAIL %s_empty: got empty=%b count=%0d exp empty=1 count=0", tag, sb_empty, sb_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({st_ready, st_misalign, mem_req, mem_be, sb_empty, sb_count} !== {1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got ready=%b mis=%b req=%b be=%b empty=%b count=%0d exp 1 0 0 0000 1 0",
                     st_ready, st_misalign, mem_req, mem_be, sb_empty, sb_count);
        end
    endtask

    task automatic test_sb_align();
        drive(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL sb_align: got req=%b addr=%h be=%b wdata=%h exp 1 00000100 1000 a5a5a5a5",
                     mem_req, mem_addr, mem_be, mem_wdata);
        end
        drive(1'b1, 3'd1, 32'h0000_0106, 32'h0000_BEEF, 1'b0);
        tick();
        drive(1'b1, 3'd2, 32'h0000_0108, 32'h1234_5678, 1'b0);
        tick();
        drain_check("align");
    endtask

    task automatic test_misalign();
        logic [2:0]  f  [3] = '{3'd1, 3'd2, 3'd3};
        logic [31:0] a  [3] = '{32'h201, 32'h202, 32'h204};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, f[i], a[i], 32'hCAFE_F00D, 1'b0);
            tick();
            drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
            checks++;
            if (st_misalign !== 1'b1 || sb_count !== 3'd0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL misalign_%0d: got mis=%b count=%0d req=%b exp 1 0 0", i, st_misalign, sb_count, mem_req);
            end
            tick();
            checks++;
            if (st_misalign !== 1'b0) begin
                errors++;
                $display("FAIL misalign_pulse_%0d: got mis=%b exp 0", i, st_misalign);
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd2, 32'h300 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b0);
            #1;
            if (i == 4) begin
                checks++;
                if (st_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready: got st_ready=%b exp 0", st_ready);
                end
            end
            tick();
        end
        drive(1'b1, 3'd1, 32'h301, 32'h0, 1'b0);
        tick();
        checks++;
        if (sb_count !== 3'd4 || st_misalign !== 1'b0 || st_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: got count=%0d mis=%b ready=%b exp 4 0 0", sb_count, st_misalign, st_ready);
        end
        drive(1'b1, 3'd2, 32'h380, 32'h0, 1'b1);
        tick();
        checks++;
        if (sb_count !== 3'd3 || st_ready !== 1'b1 || mem_addr !== 32'h304 || sb_count !== 3'(q.size())) begin
            errors++;
            $display("FAIL full_ack: got count=%0d ready=%b head=%h exp 3 1 00000304", sb_count, st_ready, mem_addr);
        end
        drain_check("full");
    endtask

    task automatic test_push_pop();
        drive(1'b1, 3'd0, 32'h10, 32'h11, 1'b0); tick();
        drive(1'b1, 3'd0, 32'h21, 32'h22, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd1, 32'h30 + 32'(4 * i) + 32'(2 * (i % 2)), 32'hA000 + 32'(i), 1'b1);
            tick();
            checks++;
            if (sb_count !== 3'd2 || mem_addr !== q[0].addr || mem_be !== q[0].be) begin
                errors++;
                $display("FAIL push_pop_%0d: got count=%0d head=%h be=%b exp 2 %h %b",
                         i, sb_count, mem_addr, mem_be, q[0].addr, q[0].be);
            end
        end
        drain_check("wrap");
    endtask

    task automatic test_hazard();
        drive(1'b1, 3'd2, 32'h400, 32'hDEAD_BEEF, 1'b0);
        ld_check = 1'b1; ld_addr = 32'h400;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_push_same_cycle: got %b exp 0", ld_hazard);
        end
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        ld_addr = 32'h403; #1;
        checks++;
        if (ld_hazard !== 1'b1) begin
            errors++;
            $display("FAIL hazard_hit: got %b exp 1", ld_hazard);
        end
        ld_addr = 32'h404; #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_next_word: got %b exp 0", ld_hazard);
        end
        ld_addr = 32'h403; ld_check = 1'b0; #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_no_check: got %b exp 0", ld_hazard);
        end
        ld_check = 1'b1; mem_ack = 1'b1; #1;
        checks++;
        if (ld_hazard !== 1'b1) begin
            errors++;
            $display("FAIL hazard_popping: got %b exp 1", ld_hazard);
        end
        tick();
        mem_ack = 1'b0; #1;
        checks++;
        if (ld_hazard !== 1'b0 || sb_empty !== 1'b1) begin
            errors++;
            $display("FAIL hazard_after_ack: got hazard=%b empty=%b exp 0 1", ld_hazard, sb_empty);
        end
        ld_check = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                  32'h1000 + 32'($urandom_range(0, 23)), $urandom, 1'($urandom_range(0, 9) < 4));
            ld_check = 1'($urandom_range(0, 1));
            ld_addr  = 32'h1000 + 32'($urandom_range(0, 27));
            #1;
            checks++;
            if (ld_hazard !== m_hazard()) begin
                errors++;
                $display("FAIL rand_hazard_%0d: got %b exp %b", n, ld_hazard, m_hazard());
            end
            tick();
            checks++;
            if (st_misalign !== exp_mis || sb_count !== 3'(q.size()) || sb_empty !== (q.size() == 0) ||
                mem_req !== (q.size() > 0) || st_ready !== (q.size() < DEPTH)) begin
                errors++;
                $display("FAIL rand_status_%0d: got mis=%b count=%0d empty=%b req=%b ready=%b exp mis=%b count=%0d",
                         n, st_misalign, sb_count, sb_empty, mem_req, st_ready, exp_mis, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if (mem_addr !== q[0].addr || mem_wdata !== q[0].wdata || mem_be !== q[0].be) begin
                    errors++;
                    $display("FAIL rand_head_%0d: got addr=%h wdata=%h be=%b exp %h %h %b",
                             n, mem_addr, mem_wdata, mem_be, q[0].addr, q[0].wdata, q[0].be);
                end
            end
        end
        ld_check = 1'b0;
        drain_check("rand");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd2, 32'h600 + 32'(4 * i), 32'(i), 1'b0);
            tick();
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        q.delete(); exp_mis = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || sb_empty !== 1'b1 || sb_count !== 3'd0 || mem_be !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: got req=%b empty=%b count=%0d be=%b exp 0 1 0 0000",
                     mem_req, sb_empty, sb_count, mem_be);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        repeat (3) tick();
        checks++;
        if (mem_req !== 1'b0 || sb_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_after: got req=%b count=%0d exp 0 0", mem_req, sb_count);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sb_align();
        test_misalign();
        test_full();
        test_push_pop();
        test_hazard();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
